// File: rtl/ping_burst_ctrl_pkg.sv
// Shared definitions for the ping burst controller: FSM state encoding and the
// default time-of-flight width, which the range/display consumer also uses.
package ping_burst_ctrl_pkg;

    localparam int TOF_W_DEFAULT = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_BURST,
        ST_BLANK,
        ST_LISTEN,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/ping_burst_ctrl_echo_sync.sv
// Two-flop synchronizer with a one-cycle rising-edge pulse, for any
// asynchronous active-high sensor input.
module ping_burst_ctrl_echo_sync (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= async_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    // sync_3 only delays the synchronized level for edge detection
    assign rise = sync_2 & ~sync_3;

endmodule

// File: rtl/ping_burst_ctrl.sv
// Sonar ping controller: gates BURST_PERIODS carrier periods onto tx_out, blanks
// for ring-down, listens for an echo and reports time of flight in clk cycles.
module ping_burst_ctrl
    import ping_burst_ctrl_pkg::*;
#(
    parameter int BURST_PERIODS = 8,
    parameter int BLANK_CYCLES  = 2000,
    parameter int TOF_LIMIT     = 200000,
    parameter int TOF_W         = TOF_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic             wave_in,
    input  logic             echo_in,
    output logic             tx_out,
    output logic             busy,
    output logic [TOF_W-1:0] tof,
    output logic             timeout,
    output logic             tof_valid,
    input  logic             tof_ready
);

    localparam int EDGE_W  = $clog2(BURST_PERIODS + 1);
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);

    state_t             state_q, state_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic [TOF_W-1:0]   tof_cnt_q, tof_cnt_d, tof_cnt_inc;
    logic [TOF_W-1:0]   tof_d;
    logic               wave_d;
    logic               tx_d, busy_d, timeout_d, valid_d;
    logic               rise;
    logic               echo_rise;

    ping_burst_ctrl_echo_sync u_echo_sync (
        .clk      (clk),
        .rstn     (rstn),
        .async_in (echo_in),
        .rise     (echo_rise)
    );

    assign rise        = wave_in & ~wave_d;
    assign tof_cnt_inc = (tof_cnt_q == '1) ? tof_cnt_q : tof_cnt_q + TOF_W'(1);

    // Result handshake: tof_valid rises together with a new tof/timeout and both
    // stay frozen until a cycle with tof_valid & tof_ready, which is the transfer.
    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        blank_d   = blank_q;
        tof_cnt_d = tof_cnt_q;
        tof_d     = tof;
        timeout_d = timeout;
        valid_d   = tof_valid;
        busy_d    = busy;
        tx_d      = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ARM;
                        busy_d  = 1'b1;
                    end
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d   = ST_BURST;
                        edge_d    = EDGE_W'(1);
                        tof_cnt_d = '0;
                        tx_d      = wave_in;
                    end
                end
                ST_BURST: begin
                    tof_cnt_d = tof_cnt_inc;
                    // the rise that would start period BURST_PERIODS+1 ends the burst
                    if (rise && edge_q == EDGE_W'(BURST_PERIODS)) begin
                        state_d = ST_BLANK;
                        blank_d = '0;
                    end else begin
                        tx_d = wave_in;
                        if (rise) begin
                            edge_d = edge_q + EDGE_W'(1);
                        end
                    end
                end
                ST_BLANK: begin
                    tof_cnt_d = tof_cnt_inc;
                    blank_d   = blank_q + BLANK_W'(1);
                    if (blank_q == BLANK_W'(BLANK_CYCLES - 1)) begin
                        state_d = ST_LISTEN;
                    end
                end
                ST_LISTEN: begin
                    tof_cnt_d = tof_cnt_inc;
                    if (echo_rise) begin
                        tof_d     = tof_cnt_q;
                        timeout_d = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = ST_REPORT;
                    end else if (tof_cnt_q == TOF_W'(TOF_LIMIT)) begin
                        tof_d     = TOF_W'(TOF_LIMIT);
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                        state_d   = ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (tof_ready) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            edge_q    <= '0;
            blank_q   <= '0;
            tof_cnt_q <= '0;
            wave_d    <= 1'b0;
            tx_out    <= 1'b0;
            busy      <= 1'b0;
            tof       <= '0;
            timeout   <= 1'b0;
            tof_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            blank_q   <= blank_d;
            tof_cnt_q <= tof_cnt_d;
            wave_d    <= wave_in;
            tx_out    <= tx_d;
            busy      <= busy_d;
            tof       <= tof_d;
            timeout   <= timeout_d;
            tof_valid <= valid_d;
        end
    end

endmodule
